// File: rtl/ram_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram_access_arbiter_pkg
// Brief  : Shared state encoding and requester indices for the RAM arbiter.
// Rev    : 1.0
// ============================================================================
package ram_access_arbiter_pkg;

    localparam int NUM_REQ   = 3;
    localparam int REQ_INIT  = 0;
    localparam int REQ_TRANS = 1;
    localparam int REQ_DISP  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ram_access_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module : rr_pick2
// Brief  : Fixed top priority for requester 0, round-robin between 1 and 2.
// Rev    : 1.0
// ============================================================================
module rr_pick2
    import ram_access_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               rr_last_i,   // 1: requester 1 won the last 1/2 contest
    output logic [NUM_REQ-1:0] winner_o
);

    always_comb begin
        winner_o = '0;
        if (req_i[REQ_INIT]) begin
            winner_o[REQ_INIT] = 1'b1;
        end else if (req_i[REQ_TRANS] && req_i[REQ_DISP]) begin
            if (rr_last_i) begin
                winner_o[REQ_DISP] = 1'b1;
            end else begin
                winner_o[REQ_TRANS] = 1'b1;
            end
        end else if (req_i[REQ_TRANS]) begin
            winner_o[REQ_TRANS] = 1'b1;
        end else if (req_i[REQ_DISP]) begin
            winner_o[REQ_DISP] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ram_access_arbiter
// Brief  : Three-way req/ack arbiter owning the single-port account RAM bus.
// Rev    : 1.0
// ============================================================================
module ram_access_arbiter
    import ram_access_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 1,
    parameter int DATA_W   = 48,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 15
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_wren,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    output logic                        ram_wren,
    input  logic [DATA_W-1:0]           ram_q
);

    localparam int LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam int LCK_W = $clog2(LOCK_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RD_LAT - 1);
    localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_MAX - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;
    logic                 ram_wren_q, ram_wren_d;
    logic                 rr_last_q, rr_last_d;
    logic [LCK_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;

    logic [NUM_REQ-1:0]   w_winner;
    logic [NUM_REQ-1:0]   w_sel;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_sel_wren;
    logic                 w_own_req;
    logic                 w_own_lock;
    logic                 w_complete;

    rr_pick2 u_rr_pick2 (
        .req_i     (req),
        .rr_last_i (rr_last_q),
        .winner_o  (w_winner)
    );

    // In HOLD the current owner is re-served without arbitration.
    assign w_sel      = (state_q == ST_HOLD) ? grant_q : w_winner;
    assign w_own_req  = |(req & grant_q);
    assign w_own_lock = |(req_lock & grant_q);

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wren  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel[i]) begin
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_sel_wren  = req_wren[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wren_d  = 1'b0;
        rr_last_d   = rr_last_q;
        lock_cnt_d  = lock_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        w_complete  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d     = w_winner;
                    ram_addr_d  = w_sel_addr;
                    ram_wdata_d = w_sel_wdata;
                    ram_wren_d  = w_sel_wren;
                    state_d     = ST_ACCESS;
                    if (w_winner[REQ_TRANS]) begin
                        rr_last_d = 1'b1;
                    end else if (w_winner[REQ_DISP]) begin
                        rr_last_d = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                if (ram_wren_q) begin
                    w_complete = 1'b1;
                end else if (RD_LAT == 1) begin
                    w_complete = 1'b1;
                    rdata_d    = ram_q;
                end else begin
                    state_d   = ST_WAIT;
                    lat_cnt_d = LAT_ONE;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    w_complete = 1'b1;
                    rdata_d    = ram_q;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_own_req) begin
                    ram_addr_d  = w_sel_addr;
                    ram_wdata_d = w_sel_wdata;
                    ram_wren_d  = w_sel_wren;
                    lock_cnt_d  = '0;
                    state_d     = ST_ACCESS;
                end else if (!w_own_lock || (lock_cnt_q == LOCK_LAST)) begin
                    grant_d    = '0;
                    lock_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Lock is judged at completion so an RMW owner can decide per access.
        if (w_complete) begin
            ack_d      = grant_q;
            lock_cnt_d = '0;
            if (w_own_lock) begin
                state_d = ST_HOLD;
            end else begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wren_q  <= 1'b0;
            rr_last_q   <= 1'b0;
            lock_cnt_q  <= '0;
            lat_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wren_q  <= ram_wren_d;
            rr_last_q   <= rr_last_d;
            lock_cnt_q  <= lock_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wren  = ram_wren_q;

endmodule
`default_nettype wire
